sync_fifo_param: RTL and testbench

Parametrised synchronous single-clock FIFO. It supersedes the fixed 16x8 buffer used between producer and consumer stages in the lab datapaths. Width and depth are generic, with an optional first-word-fall-through (FWFT) read mode. It adds exact zero-lag full/empty flags, programmable almost-full/almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags.

---
 rtl/sync_fifo_param.sv | 163 ++++++++++++++++
 tb/tb_sync_fifo_param.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Parametrised single-clock FIFO with optional first-word-fall-through read.
// The full, empty, almost_full, almost_empty and level outputs all decode
// the registered occupancy count, so none of them lags by a cycle. The
// overflow and underflow flags are sticky until err_clr is asserted.
//
// Parameters
//   WIDTH      data width in bits
//   DEPTH      number of entries (power of two, >= 2)
//   AF_THRESH  almost_full asserts when level >= AF_THRESH
//   AE_THRESH  almost_empty asserts when level <= AE_THRESH
//   FWFT       0 = registered read (1-cycle latency), 1 = first-word-fall-through
//
// Ports
//   clk          clock, rising edge
//   rst          synchronous active-low reset
//   wr_en, din   write request and data
//   rd_en        read request (pop of the current head in FWFT mode)
//   err_clr      clears overflow/underflow (a coincident error event wins)
//   dout         read data
//   dout_valid   standard mode: 1-cycle pulse per read; FWFT mode: !empty
//   full, empty, almost_full, almost_empty, level   occupancy status
//   overflow     sticky: write requested while full
//   underflow    sticky: read requested while empty
module sync_fifo_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2,
  parameter int FWFT      = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           din,
  input  logic                       rd_en,
  input  logic                       err_clr,
  output logic [WIDTH-1:0]           dout,
  output logic                       dout_valid,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
  localparam logic [LW-1:0] AF_L      = LW'(AF_THRESH);
  localparam logic [LW-1:0] AE_L      = LW'(AE_THRESH);
  localparam logic [LW-1:0] LVL_ZERO  = {LW{1'b0}};
  localparam logic [LW-1:0] LVL_ONE   = LW'(1);
  localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [LW-1:0]    count_r;
  logic             overflow_r;
  logic             underflow_r;

  logic             full_s;
  logic             empty_s;
  logic             wr_acc_s;
  logic             rd_acc_s;

  // Status decode and request acceptance from the registered count.
  // A write is refused when full even if a read is accepted in the same
  // cycle, and a read is refused when empty even alongside a write.
  always_comb begin
    full_s   = (count_r == DEPTH_L);
    empty_s  = (count_r == LVL_ZERO);
    wr_acc_s = wr_en && !full_s;
    rd_acc_s = rd_en && !empty_s;
  end

  assign full         = full_s;
  assign empty        = empty_s;
  assign almost_full  = (count_r >= AF_L);
  assign almost_empty = (count_r <= AE_L);
  assign level        = count_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

  // Storage array; not reset, and writes in the reset cycle are dropped.
  always_ff @(posedge clk) begin
    if (rst && wr_acc_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= PTR_ZERO;
      rd_ptr_r <= PTR_ZERO;
      count_r  <= LVL_ZERO;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_acc_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + LVL_ONE;
        2'b01:   count_r <= count_r - LVL_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky error flags; an error event in the err_clr cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      overflow_r  <= (wr_en && full_s)  || (overflow_r  && !err_clr);
      underflow_r <= (rd_en && empty_s) || (underflow_r && !err_clr);
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head of queue presented combinationally; forced to zero when empty.
      always_comb begin
        if (empty_s) begin
          dout = {WIDTH{1'b0}};
        end else begin
          dout = mem_r[rd_ptr_r];
        end
      end
      assign dout_valid = !empty_s;
    end else begin : g_std
      logic [WIDTH-1:0] dout_r;
      logic             dout_valid_r;

      // Registered read port: dout holds its last value between reads.
      always_ff @(posedge clk) begin
        if (!rst) begin
          dout_r       <= {WIDTH{1'b0}};
          dout_valid_r <= 1'b0;
        end else if (rd_acc_s) begin
          dout_r       <= mem_r[rd_ptr_r];
          dout_valid_r <= 1'b1;
        end else begin
          dout_r       <= dout_r;
          dout_valid_r <= 1'b0;
        end
      end

      assign dout       = dout_r;
      assign dout_valid = dout_valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: table of directed vectors on a standard-mode
// 16x8 instance, hand sequences for sustained simultaneous read/write and for
// a first-word-fall-through instance.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  // standard-mode instance
  logic       rst, wr_en, rd_en, err_clr;
  logic [7:0] din, dout;
  logic       dout_valid, full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] level;

  // FWFT instance
  logic       f_rst, f_wr_en, f_rd_en, f_err_clr;
  logic [7:0] f_din, f_dout;
  logic       f_dout_valid, f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_level;

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .err_clr(err_clr),
    .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
    .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .rst(f_rst), .wr_en(f_wr_en), .din(f_din), .rd_en(f_rd_en), .err_clr(f_err_clr),
    .dout(f_dout), .dout_valid(f_dout_valid), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .level(f_level),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  typedef struct {
    logic       rst;
    logic       wr;
    logic [7:0] din;
    logic       rd;
    logic       clr;
    logic [4:0] lvl;
    logic [7:0] dout;
    logic       dv;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic add(input logic r, input logic w, input logic [7:0] d, input logic rd,
                     input logic c, input logic [4:0] l, input logic [7:0] q,
                     input logic dv, input logic o, input logic u);
    vec_t v;
    v.rst = r; v.wr = w; v.din = d; v.rd = rd; v.clr = c;
    v.lvl = l; v.dout = q; v.dv = dv; v.ovf = o; v.udf = u;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // one clock: inputs already driven, sample on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [20:0] got_v, exp_v;
    logic        e_full, e_empty, e_af, e_ae;

    rst = 1'b0; wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0; din = 8'h00;
    f_rst = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0; f_din = 8'h00;

    // ---- vector table: rst, wr, din, rd, clr | level, dout, dv, ovf, udf ----
    add(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 16; k++)
      add(1'b1, 1'b1, 8'(k), 1'b0, 1'b0, 5'(k), 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd16, 8'h00, 1'b0, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++)
      add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'(16 - k), 8'(k), 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 8'h10, 1'b0, 1'b1, 1'b1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 8'h10, 1'b0, 1'b0, 1'b0);
    // empty: write and read together -> write taken, read refused
    add(1'b1, 1'b1, 8'h33, 1'b1, 1'b0, 5'd1, 8'h10, 1'b0, 1'b0, 1'b1);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 8'h10, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++)
      add(1'b1, 1'b1, 8'(8'h34 + i), 1'b0, 1'b0, 5'(2 + i), 8'h10, 1'b0, 1'b0, 1'b0);
    // full: write and read together -> read taken, write refused
    add(1'b1, 1'b1, 8'h99, 1'b1, 1'b0, 5'd15, 8'h33, 1'b1, 1'b1, 1'b0);
    add(1'b1, 1'b1, 8'h77, 1'b0, 1'b1, 5'd16, 8'h33, 1'b0, 1'b0, 1'b0);
    // err_clr coinciding with an overflow event: error wins
    add(1'b1, 1'b1, 8'hEE, 1'b0, 1'b1, 5'd16, 8'h33, 1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 11; k++)
      add(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'(15 - k), 8'(8'h34 + k), 1'b1, 1'b1, 1'b0);
    // level 5 with overflow set: reset with a write pending
    add(1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    add(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; wr_en = vecs[i].wr; din = vecs[i].din;
      rd_en = vecs[i].rd; err_clr = vecs[i].clr;
      step();
      e_full  = (vecs[i].lvl == 5'd16);
      e_empty = (vecs[i].lvl == 5'd0);
      e_af    = (vecs[i].lvl >= 5'd14);
      e_ae    = (vecs[i].lvl <= 5'd2);
      got_v = {level, full, empty, almost_full, almost_empty, dout, dout_valid, overflow, underflow};
      exp_v = {vecs[i].lvl, e_full, e_empty, e_af, e_ae, vecs[i].dout, vecs[i].dv,
               vecs[i].ovf, vecs[i].udf};
      chk($sformatf("vec%0d {lvl,full,empty,af,ae,dout,dv,ovf,udf}", i), 32'(got_v), 32'(exp_v));
    end

    // ---- sustained simultaneous read/write at level 8 ----
    rd_en = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; din = 8'(i);
      step();
    end
    chk("b2b_prefill_level", 32'(level), 32'd8);
    for (int i = 0; i < 40; i++) begin
      wr_en = 1'b1; rd_en = 1'b1; din = 8'(8 + i);
      step();
      chk($sformatf("b2b%0d {level,dout,dv}", i), {19'd0, level, dout},
          {19'd0, 5'd8, 8'(i)});
      chk($sformatf("b2b%0d dv", i), 32'(dout_valid), 32'd1);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    chk("b2b_no_errors", {30'd0, overflow, underflow}, 32'd0);

    // ---- first-word-fall-through instance ----
    f_rst = 1'b0;
    step();
    chk("fw_reset {empty,dv,dout}", {22'd0, f_empty, f_dout_valid, f_dout}, {22'd0, 1'b1, 1'b0, 8'h00});
    f_rst = 1'b1; f_wr_en = 1'b1; f_din = 8'h5A;
    step();
    f_wr_en = 1'b0;
    chk("fw_first {empty,dv,dout}", {22'd0, f_empty, f_dout_valid, f_dout}, {22'd0, 1'b0, 1'b1, 8'h5A});
    f_rd_en = 1'b1;
    step();
    f_rd_en = 1'b0;
    chk("fw_pop {empty,dv}", {30'd0, f_empty, f_dout_valid}, {30'd0, 1'b1, 1'b0});
    f_wr_en = 1'b1; f_din = 8'h11;
    step();
    f_din = 8'h22;
    step();
    f_wr_en = 1'b0;
    chk("fw_head {level,dout}", {19'd0, f_level, f_dout}, {19'd0, 5'd2, 8'h11});
    f_rd_en = 1'b1;
    step();
    f_rd_en = 1'b0;
    chk("fw_next {level,dout}", {19'd0, f_level, f_dout}, {19'd0, 5'd1, 8'h22});
    chk("fw_no_errors", {30'd0, f_overflow, f_underflow}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
